// File: rtl/fpu_pkg.sv
// Shared FPU definitions: channel enumeration, writeback record and sizing constants.
`default_nettype none

package fpu_pkg;

    localparam int NUM_FPU_CH = 6;
    localparam int FPU_DATA_W = 32;
    localparam int FPU_DEST_W = 5;

    typedef enum logic [2:0] {
        ADD  = 3'd0,
        MULT = 3'd1,
        I2F  = 3'd2,
        F2I  = 3'd3,
        CMP  = 3'd4,
        DIV  = 3'd5
    } fpu_ch_e;

    typedef struct packed {
        logic [FPU_DATA_W-1:0] data;
        logic [FPU_DEST_W-1:0] dest;
    } fpu_wb_t;

endpackage

`default_nettype wire

// File: rtl/fpu_wb_fifo.sv
// Per-channel result FIFO; DEPTH must be a power of two so pointers wrap naturally.
`default_nettype none

module fpu_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: an entry is only observed once count covers it.
    always_ff @(posedge clock) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/fpu_wb_arbiter.sv
// Collects FPU unit results into per-channel FIFOs and arbitrates them onto one
// registered writeback port. Define FPU_WB_ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
`default_nettype none

module fpu_wb_arbiter
    import fpu_pkg::*;
#(
    parameter int NUM_CH = NUM_FPU_CH,
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int DEST_W = 5
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic [NUM_CH-1:0]              in_valid,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  in_data,
    input  logic [NUM_CH-1:0][DEST_W-1:0]  in_dest,
    output logic [NUM_CH-1:0]              in_ready,
    output logic                           out_valid,
    output logic [DATA_W-1:0]              out_data,
    output logic [DEST_W-1:0]              out_dest,
    output logic [$clog2(NUM_CH)-1:0]      out_ch,
    input  logic                           out_ready,
    output logic                           busy,
    output logic [NUM_CH-1:0]              overflow
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int ENT_W = DATA_W + DEST_W;

    logic [NUM_CH-1:0]            full;
    logic [NUM_CH-1:0]            empty;
    logic [NUM_CH-1:0]            push;
    logic [NUM_CH-1:0]            pop;
    logic [NUM_CH-1:0][ENT_W-1:0] head;

    logic                         grant_valid;
    logic [CH_W-1:0]              grant_idx;
    logic                         load;

    logic                         out_valid_q, out_valid_d;
    logic [DATA_W-1:0]            out_data_q,  out_data_d;
    logic [DEST_W-1:0]            out_dest_q,  out_dest_d;
    logic [CH_W-1:0]              out_ch_q,    out_ch_d;
    logic [NUM_CH-1:0]            overflow_q,  overflow_d;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        fpu_wb_fifo #(
            .DEPTH (DEPTH),
            .W     (ENT_W)
        ) u_fifo (
            .clock   (clock),
            .resetn  (resetn),
            .push_i  (push[g]),
            .pop_i   (pop[g]),
            .wdata_i ({in_data[g], in_dest[g]}),
            .head_o  (head[g]),
            .full_o  (full[g]),
            .empty_o (empty[g])
        );
    end

    // Ready depends on registered count only; a same-cycle pop never frees a slot early.
    assign in_ready = ~full;
    assign push     = in_valid & ~full;
    assign load     = !out_valid_q || out_ready;
    assign pop      = (load && grant_valid) ? (NUM_CH'(1) << grant_idx) : '0;

`ifdef FPU_WB_ARB_ROUND_ROBIN_EN
    logic [CH_W-1:0] last_grant_q, last_grant_d;

    // Walk candidates from farthest to nearest so the one right after last_grant wins.
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = (int'(last_grant_q) + k) % NUM_CH;
            if (!empty[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = CH_W'(idx);
            end
        end
    end

    assign last_grant_d = (load && grant_valid) ? grant_idx : last_grant_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) last_grant_q <= CH_W'(NUM_CH - 1);
        else         last_grant_q <= last_grant_d;
    end
`else
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (!empty[k]) begin
                grant_valid = 1'b1;
                grant_idx   = CH_W'(k);
            end
        end
    end
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_dest_d  = out_dest_q;
        out_ch_d    = out_ch_q;
        overflow_d  = overflow_q | (in_valid & full);
        if (load) begin
            if (grant_valid) begin
                out_valid_d              = 1'b1;
                {out_data_d, out_dest_d} = head[grant_idx];
                out_ch_d                 = grant_idx;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_dest_q  <= '0;
            out_ch_q    <= '0;
            overflow_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_dest_q  <= out_dest_d;
            out_ch_q    <= out_ch_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_dest  = out_dest_q;
    assign out_ch    = out_ch_q;
    assign overflow  = overflow_q;
    assign busy      = (~&empty) | out_valid_q;

endmodule

`default_nettype wire

// File: doc/fpu_wb_arbiter.md
# fpu_wb_arbiter

Parametrised writeback collector for the FPU. It accepts finished results from `NUM_CH` independent FPU execution units, buffers each channel in its own small FIFO, and arbitrates them onto a single registered writeback port with ready/valid backpressure toward the register file. It sits between the FPU functional units and the CPU writeback stage. Because every channel is buffered, multiple units may finish in the same cycle without losing results.

## Interface
Parameters:
- `NUM_CH`, 6: number of producer channels (add, mult, i2f, f2i, cmp, div).
- `DEPTH`, 2: entries per channel FIFO; must be a power of two, ≥2.
- `DATA_W`, 32: result width.
- `DEST_W`, 5: destination register index width.

Ports (name, direction, width, meaning):
- `clock`, in, 1: single clock; all state updates on the rising edge.
- `resetn`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, `NUM_CH`: channel `i` presents a result this cycle.
- `in_data`, in, `NUM_CH`×`DATA_W`: per-channel result.
- `in_dest`, in, `NUM_CH`×`DEST_W`: per-channel destination register.
- `in_ready`, out, `NUM_CH`: channel FIFO not full.
- `out_valid`, out, 1: writeback register holds a result.
- `out_data`, out, `DATA_W`: result.
- `out_dest`, out, `DEST_W`: destination register.
- `out_ch`, out, `$clog2(NUM_CH)`: source channel of the current output.
- `out_ready`, in, 1: writeback stage consumes the output this cycle.
- `busy`, out, 1: any FIFO non-empty or `out_valid` is high.
- `overflow`, out, `NUM_CH`: sticky per-channel flag for a dropped result.

## Operation
- Push: at an edge where `in_valid[i] && in_ready[i]`, write {`in_data[i]`, `in_dest[i]`} at the channel's write pointer, advance the pointer modulo `DEPTH`, and increment the count.
- `in_ready[i] = (count[i] != DEPTH)`. A pop in the same cycle is not considered, so a full FIFO refuses input even while it drains.
- Overflow: `in_valid[i] && !in_ready[i]` drops the result and sets `overflow[i]`. Only reset clears the flag.
- Output register load condition: `!out_valid || out_ready`. When this holds and at least one FIFO is non-empty, grant one non-empty channel, pop its head into the output register, and set `out_ch`.
- When the load condition holds and no FIFO is non-empty, clear `out_valid`.
- When `out_valid && !out_ready`, the output register and all heads hold.
- A simultaneous push and pop on the same channel leaves the count unchanged. Both pointers advance.
- Count width is `$clog2(DEPTH+1)`. Pointer width is `$clog2(DEPTH)` and wraps naturally.
- Reset while entries are in flight discards them all: counts, pointers, `out_valid` and `overflow` go to 0, and the arbitration pointer goes to `NUM_CH-1`.
- Reset values: `out_valid`=0, `out_data`=0, `out_dest`=0, `out_ch`=0, `overflow`=0, `busy`=0, and `in_ready`=all ones.

## Timing
- Minimum latency is 2 edges: push at edge E makes the head visible after E, the output register loads at E+1, and `out_valid` is high in the cycle after E+1.
- Sustained throughput is one result per cycle while `out_ready` is held high.
- Per-channel order is preserved (FIFO). There is no ordering guarantee across channels.
- `in_ready`, `busy` and arbitration are combinational from registered state only. There is no combinational path from `in_valid` or `out_ready` to `in_ready`.

## Configuration
- `FPU_WB_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration. A `last_grant` register is updated only on a grant. The search starts at `last_grant+1` and wraps at `NUM_CH`.
- Not defined: fixed priority, where the lowest non-empty channel index wins. There is no `last_grant` register. Starvation of high-index channels is permitted.

## Structure
- Shared package `fpu_pkg`:
  - `NUM_FPU_CH` constant.
  - Channel index enum `fpu_ch_e` (ADD=0, MULT=1, I2F=2, F2I=3, CMP=4, DIV=5).
  - Struct `fpu_wb_t` {data, dest}.
- Sub-module `fpu_wb_fifo`: one parametrised FIFO instance per channel, generated in a loop, exposing full, empty, push, pop and head.
- The arbiter and output register live in the top module.

## Test plan
- Single push on ch2 (data 0x3F800000, dest 7) with `out_ready`=1 -> `out_valid` high two edges later, `out_data`=0x3F800000, `out_dest`=7, `out_ch`=2, and it drops after one cycle.
- All six channels push in the same cycle, `out_ready`=1 -> six consecutive outputs. Round-robin order from reset is ch0..ch5; fixed priority gives the same order.
- ch0 and ch3 push continuously with round-robin enabled -> outputs alternate 0,3,0,3. With fixed priority, ch0 wins every cycle while non-empty.
- `out_ready`=0, ch1 pushes 3 times with `DEPTH`=2 -> the first enters the output register, the second and third fill the FIFO, `in_ready[1]`=0, and a fourth push sets `overflow[1]`. Raising `out_ready` then delivers exactly 3 results in order.
- Push on ch4, then assert `resetn`=0 mid-flight -> `out_valid`, `busy` and `overflow` go to 0 immediately (asynchronously), and no stale result appears after reset release.
- Same-cycle push and pop on a full ch5 FIFO -> the push is refused and flagged (`in_ready`=0), the count drops to `DEPTH-1`, and the next push is accepted.
